dbus_ctrl: RTL and testbench

- Data-bus controller between the core load/store unit and the data-side slaves (DMEM, TBMAN).
- Decodes the request address and drives the active-low chip selects `cs_dmem_n`/`cs_tbman_n` consumed by the read-data mux.
- Inserts per-slave wait states, captures the muxed read data and returns a one-cycle `ready` (with `err` for unmapped or misaligned accesses) to the requester.

---
 rtl/dbus_pkg.sv | 41 ++++
 rtl/dbus_addr_dec.sv | 40 ++++
 rtl/dbus_ctrl.sv | 140 ++++++++++++++
 tb/tb_dbus_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Data-bus controller shared types and defaults.
// FSM states, slave regions and the registered slave request bundle.
package dbus_pkg;

  localparam int CNT_W = 4;

  localparam logic [31:0] DEF_DMEM_BASE  = 32'h1000_0000;
  localparam int          DEF_DMEM_AW    = 16;
  localparam logic [31:0] DEF_TBMAN_BASE = 32'h8000_0000;
  localparam int          DEF_TBMAN_AW   = 12;
  localparam int          DEF_DMEM_WAIT  = 1;
  localparam int          DEF_TBMAN_WAIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DMEM,
    REG_TBMAN
  } region_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
  } mem_req_t;

  // Saturate so an oversized wait setting can never wrap the counter.
  function automatic logic [CNT_W-1:0] wait_cnt(input int w);
    if (w > 15) return '1;
    if (w < 0) return '0;
    return w[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/dbus_addr_dec.sv
// Data-bus address decoder: region select and alignment check.
// DMEM takes priority where the two regions overlap.
import dbus_pkg::*;

module dbus_addr_dec #(
  parameter logic [31:0] DMEM_BASE  = DEF_DMEM_BASE,
  parameter int          DMEM_AW    = DEF_DMEM_AW,
  parameter logic [31:0] TBMAN_BASE = DEF_TBMAN_BASE,
  parameter int          TBMAN_AW   = DEF_TBMAN_AW
) (
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  output region_t     region,
  output logic        misaligned
);

  logic hit_dmem;
  logic hit_tbman;
  logic unused_addr;

  assign hit_dmem =
    addr[31:DMEM_AW] == DMEM_BASE[31:DMEM_AW];
  assign hit_tbman =
    addr[31:TBMAN_AW] == TBMAN_BASE[31:TBMAN_AW];

  assign unused_addr = ^addr;

  always_comb begin
    region = REG_NONE;
    if (hit_dmem)
      region = REG_DMEM;
    else if (hit_tbman)
      region = REG_TBMAN;
  end

  assign misaligned =
    (be == 4'hF && addr[1:0] != 2'b00) ||
    (be == 4'h0);

endmodule

// File: rtl/dbus_ctrl.sv
// Data-bus controller: decode, chip select, wait states
// and a single-cycle ready/err response to the LSU.
import dbus_pkg::*;

module dbus_ctrl #(
  parameter logic [31:0] DMEM_BASE  = DEF_DMEM_BASE,
  parameter int          DMEM_AW    = DEF_DMEM_AW,
  parameter logic [31:0] TBMAN_BASE = DEF_TBMAN_BASE,
  parameter int          TBMAN_AW   = DEF_TBMAN_AW,
  parameter int          DMEM_WAIT  = DEF_DMEM_WAIT,
  parameter int          TBMAN_WAIT = DEF_TBMAN_WAIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic        err,
  output logic [31:0] rdata,
  output logic        cs_dmem_n,
  output logic        cs_tbman_n,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  input  logic [31:0] read_data
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             cs_dmem_q, cs_dmem_d;
  logic             cs_tbman_q, cs_tbman_d;
  mem_req_t         mreq_q, mreq_d;

  region_t          region;
  logic             misaligned;

  dbus_addr_dec #(
    .DMEM_BASE  (DMEM_BASE),
    .DMEM_AW    (DMEM_AW),
    .TBMAN_BASE (TBMAN_BASE),
    .TBMAN_AW   (TBMAN_AW)
  ) u_dec (
    .addr       (addr),
    .be         (be),
    .region     (region),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = 1'b0;
    err_d      = err_q;
    rdata_d    = rdata_q;
    cs_dmem_d  = cs_dmem_q;
    cs_tbman_d = cs_tbman_q;
    mreq_d     = mreq_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (region == REG_NONE || misaligned) begin
            state_d = ERR;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            mreq_d  = '{addr: addr, wdata: wdata,
                        we: we, be: be};
            if (region == REG_DMEM) begin
              cs_dmem_d = 1'b0;
              cnt_d     = wait_cnt(DMEM_WAIT);
            end else begin
              cs_tbman_d = 1'b0;
              cnt_d      = wait_cnt(TBMAN_WAIT);
            end
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!mreq_q.we)
            rdata_d = read_data;
          ready_d    = 1'b1;
          err_d      = 1'b0;
          cs_dmem_d  = 1'b1;
          cs_tbman_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: state_d = IDLE;
      ERR: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      cs_dmem_q  <= 1'b1;
      cs_tbman_q <= 1'b1;
      mreq_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      cs_dmem_q  <= cs_dmem_d;
      cs_tbman_q <= cs_tbman_d;
      mreq_q     <= mreq_d;
    end
  end

  assign ready      = ready_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign cs_dmem_n  = cs_dmem_q;
  assign cs_tbman_n = cs_tbman_q;
  assign mem_addr   = mreq_q.addr;
  assign mem_wdata  = mreq_q.wdata;
  assign mem_we     = mreq_q.we;
  assign mem_be     = mreq_q.be;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Bench for dbus_ctrl: scoreboarded responses plus
// latency, chip-select and reset checks.
module tb_dbus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic        err;
  logic [31:0] rdata;
  logic        cs_dmem_n;
  logic        cs_tbman_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] read_data;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  dbus_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .be         (be),
    .ready      (ready),
    .err        (err),
    .rdata      (rdata),
    .cs_dmem_n  (cs_dmem_n),
    .cs_tbman_n (cs_tbman_n),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .read_data  (read_data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Response monitor and chip-select exclusivity.
  always @(negedge clk) begin
    exp_t e;
    chk("cs_excl",
        {31'b0, !cs_dmem_n && !cs_tbman_n}, 32'd0);
    if (ready) begin
      if (sb.size() == 0) begin
        chk("spurious_ready", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_err", {31'b0, err}, {31'b0, e.err});
        chk("resp_rdata", rdata, e.rdata);
      end
    end
  end

  // rgn: 0 unmapped/error, 1 DMEM, 2 TBMAN
  task automatic access(input logic        w,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0]  b,
                        input logic [31:0] rd,
                        input logic        exp_err,
                        input int          rgn,
                        input int          wt,
                        input string       tag);
    exp_t e;
    int   lat;
    int   nd;
    int   nt;
    bit   seen;
    lat  = 0;
    nd   = 0;
    nt   = 0;
    seen = 1'b0;
    e.err   = exp_err;
    e.rdata = (exp_err || w) ? model_rdata : rd;
    sb.push_back(e);
    req       = 1'b1;
    we        = w;
    addr      = a;
    wdata     = d;
    be        = b;
    read_data = rd;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (!cs_dmem_n) nd++;
      if (!cs_tbman_n) nt++;
      if (!cs_dmem_n || !cs_tbman_n) begin
        chk({tag, "_maddr"}, mem_addr, a);
        chk({tag, "_mwe"}, {31'b0, mem_we}, {31'b0, w});
        chk({tag, "_mbe"}, {28'b0, mem_be}, {28'b0, b});
        if (w) chk({tag, "_mwdata"}, mem_wdata, d);
      end
      if (ready) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_lat"}, lat, exp_err ? 1 : wt + 2);
      chk({tag, "_cs_dmem"}, nd, rgn == 1 ? wt + 1 : 0);
      chk({tag, "_cs_tbman"}, nt, rgn == 2 ? wt + 1 : 0);
    end
    if (!exp_err && !w) model_rdata = rd;
    req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    req         = 1'b1;
    we          = 1'b0;
    addr        = 32'h1000_0040;
    wdata       = 32'h0;
    be          = 4'hF;
    read_data   = 32'hDEAD_BEEF;
    model_rdata = 32'h0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_cs_dmem", {31'b0, cs_dmem_n}, 32'd1);
      chk("rst_cs_tbman", {31'b0, cs_tbman_n}, 32'd1);
      chk("rst_ready", {31'b0, ready}, 32'd0);
      chk("rst_rdata", rdata, 32'h0);
    end
    req   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    access(0, 32'h1000_0040, 32'h0, 4'hF,
           32'hCAFE_F00D, 0, 1, 1, "ld_dmem");
    access(1, 32'h8000_0004, 32'h1234_5678, 4'hF,
           32'h5555_AAAA, 0, 2, 0, "st_tbman");
    access(0, 32'h2000_0000, 32'h0, 4'hF,
           32'h1111_1111, 1, 0, 0, "unmapped");
    access(0, 32'h1000_0002, 32'h0, 4'hF,
           32'h2222_2222, 1, 0, 0, "misalign");
    access(0, 32'h1000_0002, 32'h0, 4'b0001,
           32'h0000_00AB, 0, 1, 1, "byte_ld");
    access(0, 32'h1000_0010, 32'h0, 4'h0,
           32'h3333_3333, 1, 0, 0, "be_zero");
    access(0, 32'h1000_FFFC, 32'h0, 4'hF,
           32'hA5A5_0001, 0, 1, 1, "b2b_dmem");
    access(0, 32'h8000_0FFC, 32'h0, 4'hF,
           32'h5A5A_0002, 0, 2, 0, "b2b_tbman");
    access(0, 32'h1001_0000, 32'h0, 4'hF,
           32'h4444_4444, 1, 0, 0, "dmem_past_end");
    access(0, 32'h8000_1000, 32'h0, 4'hF,
           32'h6666_6666, 1, 0, 0, "tbman_past_end");

    // Abort a DMEM load with an asynchronous reset.
    req       = 1'b1;
    we        = 1'b0;
    addr      = 32'h1000_0080;
    be        = 4'hF;
    read_data = 32'h7777_7777;
    @(negedge clk);
    chk("mid_cs_low", {31'b0, cs_dmem_n}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_cs_async", {31'b0, cs_dmem_n}, 32'd1);
    chk("mid_ready", {31'b0, ready}, 32'd0);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rdata", rdata, 32'h0);
    model_rdata = 32'h0;
    rst_n = 1'b1;
    @(negedge clk);

    access(0, 32'h1000_0100, 32'h0, 4'hF,
           32'hBEEF_0003, 0, 1, 1, "post_rst");

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
